octavo_io_port_endpoint: RTL

//  Device-side end of one Octavo I/O port pair. Feeds the CPU read port through an inbound FIFO
//  and drains the CPU write port through an outbound FIFO. Presents io_read_EF/io_read_data and
//  io_write_EF, and consumes io_rden/io_wren/io_write_data. Ready/valid streams face external logic.

---
 rtl/octavo_io_port_endpoint_if.sv | 40 ++++
 rtl/octavo_io_port_endpoint.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/octavo_io_port_endpoint_if.sv
`default_nettype none
// ============================================================================
// Module  : octavo_io_port_endpoint_if
// Purpose : Bundles the external ready/valid streams and the CPU-side Octavo
//           I/O port signals of one port endpoint.
// Ports   : in_data/in_valid/in_ready        - inbound stream from external logic
//           io_read_EF/io_read_data/io_rden  - CPU read port
//           io_write_EF/io_write_data/io_wren- CPU write port
//           out_data/out_valid/out_ready     - outbound stream to external logic
// Modports: slave  - the endpoint itself
//           master - everything around it (CPU and external logic)
// Revision: 1.0 - initial release
// ============================================================================
interface octavo_io_port_endpoint_if #(
   parameter int WORD_WIDTH = 36
);
   logic [WORD_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  io_read_EF;
   logic [WORD_WIDTH-1:0] io_read_data;
   logic                  io_rden;
   logic                  io_write_EF;
   logic [WORD_WIDTH-1:0] io_write_data;
   logic                  io_wren;
   logic [WORD_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport slave (
      input  in_data, in_valid, io_rden, io_write_data, io_wren, out_ready,
      output in_ready, io_read_EF, io_read_data, io_write_EF, out_data, out_valid
   );

   modport master (
      output in_data, in_valid, io_rden, io_write_data, io_wren, out_ready,
      input  in_ready, io_read_EF, io_read_data, io_write_EF, out_data, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/octavo_io_port_endpoint.sv
`default_nettype none
// ============================================================================
// Module  : octavo_io_port_endpoint
// Purpose : Device-side end of one Octavo I/O port pair. An inbound circular
//           FIFO feeds the CPU read port; an outbound circular FIFO drains the
//           CPU write port. State is only pointers and occupancy counts.
// Ports   : clk  - single clock
//           rst  - synchronous, active-high reset
//           bus  - octavo_io_port_endpoint_if.slave (streams + CPU port)
//           o_err_underflow / o_err_overflow / o_words_out
//                - only when OCTAVO_IO_ENDPOINT_STATS_EN is defined
// Macro   : OCTAVO_IO_ENDPOINT_STATS_EN - adds sticky error flags and an
//           outbound word counter
// Revision: 1.0 - initial release
// ============================================================================
module octavo_io_port_endpoint #(
   parameter int WORD_WIDTH = 36,
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 2
) (
   input  wire logic                    clk,
   input  wire logic                    rst,
`ifdef OCTAVO_IO_ENDPOINT_STATS_EN
   output      logic                    o_err_underflow,
   output      logic                    o_err_overflow,
   output      logic [15:0]             o_words_out,
`endif
   octavo_io_port_endpoint_if.slave     bus
);

   localparam logic [ADDR_WIDTH:0]   c_FULL     = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   c_EMPTY    = '0;
   localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   c_CNT_ONE  = (ADDR_WIDTH+1)'(1);

   // ---------------- inbound FIFO (external -> CPU) ----------------
   logic [WORD_WIDTH-1:0] r_mem_in [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr_in;
   logic [ADDR_WIDTH-1:0] r_rd_ptr_in;
   logic [ADDR_WIDTH:0]   r_count_in;
   logic                  w_in_ready;
   logic                  w_read_ef;
   logic                  w_in_push;
   logic                  w_in_pop;

   // Flags depend only on registered counts (and reset), never on io_rden,
   // so a pop cannot combinationally raise in_ready in the same cycle.
   assign w_in_ready = rst | (r_count_in != c_FULL);
   assign w_read_ef  = ~rst & (r_count_in != c_EMPTY);
   assign w_in_push  = bus.in_valid & w_in_ready;
   assign w_in_pop   = bus.io_rden & w_read_ef;

   assign bus.in_ready     = w_in_ready;
   assign bus.io_read_EF   = w_read_ef;
   assign bus.io_read_data = r_mem_in[r_rd_ptr_in];

   always_ff @(posedge clk) begin
      if (w_in_push) begin
         r_mem_in[r_wr_ptr_in] <= bus.in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr_in <= '0;
         r_rd_ptr_in <= '0;
         r_count_in  <= '0;
      end else begin
         if (w_in_push) r_wr_ptr_in <= r_wr_ptr_in + c_PTR_ONE;
         if (w_in_pop)  r_rd_ptr_in <= r_rd_ptr_in + c_PTR_ONE;
         // Simultaneous push and pop leaves the count unchanged.
         case ({w_in_push, w_in_pop})
            2'b10:   r_count_in <= r_count_in + c_CNT_ONE;
            2'b01:   r_count_in <= r_count_in - c_CNT_ONE;
            default: r_count_in <= r_count_in;
         endcase
      end
   end

   // ---------------- outbound FIFO (CPU -> external) ----------------
   logic [WORD_WIDTH-1:0] r_mem_out [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr_out;
   logic [ADDR_WIDTH-1:0] r_rd_ptr_out;
   logic [ADDR_WIDTH:0]   r_count_out;
   logic                  w_write_ef;
   logic                  w_out_valid;
   logic                  w_out_push;
   logic                  w_out_pop;

   assign w_write_ef  = ~rst & (r_count_out == c_FULL);
   assign w_out_valid = ~rst & (r_count_out != c_EMPTY);
   assign w_out_push  = bus.io_wren & ~w_write_ef;
   assign w_out_pop   = w_out_valid & bus.out_ready;

   assign bus.io_write_EF = w_write_ef;
   assign bus.out_valid   = w_out_valid;
   assign bus.out_data    = r_mem_out[r_rd_ptr_out];

   always_ff @(posedge clk) begin
      if (w_out_push) begin
         r_mem_out[r_wr_ptr_out] <= bus.io_write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr_out <= '0;
         r_rd_ptr_out <= '0;
         r_count_out  <= '0;
      end else begin
         if (w_out_push) r_wr_ptr_out <= r_wr_ptr_out + c_PTR_ONE;
         if (w_out_pop)  r_rd_ptr_out <= r_rd_ptr_out + c_PTR_ONE;
         case ({w_out_push, w_out_pop})
            2'b10:   r_count_out <= r_count_out + c_CNT_ONE;
            2'b01:   r_count_out <= r_count_out - c_CNT_ONE;
            default: r_count_out <= r_count_out;
         endcase
      end
   end

`ifdef OCTAVO_IO_ENDPOINT_STATS_EN
   // ---------------- optional statistics ----------------
   logic        r_err_underflow;
   logic        r_err_overflow;
   logic [15:0] r_words_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_underflow <= 1'b0;
         r_err_overflow  <= 1'b0;
         r_words_out     <= '0;
      end else begin
         if (bus.io_rden & ~w_read_ef) r_err_underflow <= 1'b1;
         if (bus.io_wren & w_write_ef) r_err_overflow  <= 1'b1;
         if (w_out_pop)                r_words_out     <= r_words_out + 16'd1;
      end
   end

   assign o_err_underflow = r_err_underflow;
   assign o_err_overflow  = r_err_overflow;
   assign o_words_out     = r_words_out;
`endif

endmodule
`default_nettype wire
